// File: rtl/alu_pkg.sv
// Shared ALU control code map, FSM state type and code classification helpers.
// The SHIFT state exists only when ALU_BARREL_SHIFT_EN is undefined.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_SLT  = 4'b0110,
    OP_SLTU = 4'b0111,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1010,
    OP_XOR  = 4'b1100,
    OP_NOR  = 4'b1101,
    OP_LUI  = 4'b1110
  } alu_op_e;

`ifdef ALU_BARREL_SHIFT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd2
  } alu_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;
`endif

  function automatic logic is_legal(input logic [3:0] code);
    case (code)
      4'b0100, 4'b0101, 4'b1011, 4'b1111: return 1'b0;
      default:                            return 1'b1;
    endcase
  endfunction

  function automatic logic is_shift(input logic [3:0] code);
    return (code == OP_SLL) || (code == OP_SRL) || (code == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_shifter.sv
// Shift unit: full barrel shifter when ALU_BARREL_SHIFT_EN is defined,
// otherwise a single 1-bit step applied once per SHIFT cycle by alu_exec.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef ALU_BARREL_SHIFT_EN
  , parameter int SHAMT_W = $clog2(WIDTH)
`endif
) (
  input  logic [3:0]         i_ctl,
  input  logic [WIDTH-1:0]   i_data,
`ifdef ALU_BARREL_SHIFT_EN
  input  logic [SHAMT_W-1:0] i_shamt,
`endif
  output logic [WIDTH-1:0]   o_data
);

  always_comb begin
    o_data = i_data;
    case (i_ctl)
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL:  o_data = i_data << i_shamt;
      OP_SRL:  o_data = i_data >> i_shamt;
      OP_SRA:  o_data = $signed(i_data) >>> i_shamt;
`else
      OP_SLL:  o_data = {i_data[WIDTH-2:0], 1'b0};
      OP_SRL:  o_data = {1'b0, i_data[WIDTH-1:1]};
      OP_SRA:  o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
`endif
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Handshaked ALU execution unit with registered result and flags.
// ALU_BARREL_SHIFT_EN selects single-cycle shifts; otherwise shifts iterate 1 bit/cycle.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_ctl,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal
);

  alu_state_e r_state, w_state_nxt, w_accept_tgt;
  logic [WIDTH-1:0] r_result;
  logic r_zero, r_ovf, r_illegal;
  logic w_accept, w_ovf;
  logic [WIDTH-1:0] w_res, w_sum, w_diff, w_shift_out;
  logic signed [WIDTH-1:0] w_a_s, w_b_s;

  function automatic logic add_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] s);
    return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endfunction

  function automatic logic sub_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic [WIDTH-1:0] d);
    return (x[WIDTH-1] != y[WIDTH-1]) && (d[WIDTH-1] != x[WIDTH-1]);
  endfunction

`ifdef ALU_BARREL_SHIFT_EN
  alu_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
    .i_ctl   (alu_ctl),
    .i_data  (b),
    .i_shamt (shamt),
    .o_data  (w_shift_out)
  );
  assign w_accept_tgt = ST_DONE;
`else
  logic [SHAMT_W-1:0] r_cnt;
  logic [3:0]         r_op;

  // The held result doubles as the shift accumulator while in SHIFT.
  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .i_ctl  (r_op),
    .i_data (r_result),
    .o_data (w_shift_out)
  );
  assign w_accept_tgt = (is_shift(alu_ctl) && (shamt != '0)) ? ST_SHIFT : ST_DONE;
`endif

  assign w_a_s  = a;
  assign w_b_s  = b;
  assign w_sum  = a + b;
  assign w_diff = a - b;

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (alu_ctl)
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_ADD:  begin w_res = w_sum;  w_ovf = add_ovf(a, b, w_sum);  end
      OP_SUB:  begin w_res = w_diff; w_ovf = sub_ovf(a, b, w_diff); end
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (a < b)};
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL, OP_SRL, OP_SRA: w_res = w_shift_out;
`endif
      OP_XOR:  w_res = a ^ b;
      OP_NOR:  w_res = ~(a | b);
      OP_LUI:  w_res = b << (WIDTH / 2);
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_accept_tgt;
      end
      ST_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = in_valid ? w_accept_tgt : ST_IDLE;
      end
`ifndef ALU_BARREL_SHIFT_EN
      ST_SHIFT: begin
        if (r_cnt == SHAMT_W'(1)) w_state_nxt = ST_DONE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Result/flag capture on accept; iterative shifts then step the held value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_illegal <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      r_cnt     <= '0;
      r_op      <= '0;
`endif
    end else if (w_accept) begin
`ifndef ALU_BARREL_SHIFT_EN
      if (is_shift(alu_ctl)) begin
        r_result  <= b;
        r_zero    <= (b == '0);
        r_ovf     <= 1'b0;
        r_illegal <= 1'b0;
        r_cnt     <= shamt;
        r_op      <= alu_ctl;
      end else begin
        r_result  <= w_res;
        r_zero    <= (w_res == '0);
        r_ovf     <= w_ovf;
        r_illegal <= !is_legal(alu_ctl);
      end
`else
      r_result  <= w_res;
      r_zero    <= (w_res == '0);
      r_ovf     <= w_ovf;
      r_illegal <= !is_legal(alu_ctl);
`endif
    end
`ifndef ALU_BARREL_SHIFT_EN
    else if (r_state == ST_SHIFT) begin
      r_result <= w_shift_out;
      r_zero   <= (w_shift_out == '0);
      r_cnt    <= r_cnt - SHAMT_W'(1);
    end
`endif
  end

  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_ovf;
  assign illegal  = r_illegal;

endmodule
